// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle instruction sequencer.
package seq_pkg;

  typedef enum logic [2:0] {OpNone, OpAdd32, OpMul, OpPush, OpPop} op_e;

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [1:0] ModeData  = 2'b00;
  localparam logic [1:0] ModeStack = 2'b11;

  localparam logic [3:0] OpcAdd32 = 4'b0011;
  localparam logic [3:0] OpcMul   = 4'b1110;

  localparam logic [3:0] ExeAdd   = 4'b0010;
  localparam logic [3:0] ExeAdc   = 4'b0011;
  localparam logic [3:0] ExeSub   = 4'b0100;
  localparam logic [3:0] ExeMulLo = 4'b1100;
  localparam logic [3:0] ExeMulHi = 4'b1101;

  typedef struct packed {
    logic       valid;
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       sp_sel;
    logic       hi_sel;
    logic       carry_hold;
    logic       last;
  } uop_t;

  function automatic op_e decode_op(input logic [1:0] mode, input logic [3:0] opcode,
                                    input logic status);
    op_e op;
    op = OpNone;
    if (mode == ModeData && opcode == OpcAdd32) op = OpAdd32;
    else if (mode == ModeData && opcode == OpcMul) op = OpMul;
    else if (mode == ModeStack) op = status ? OpPop : OpPush;
    return op;
  endfunction

endpackage

// File: rtl/seq_uop_rom.sv
// Combinational micro-op table: (op class, step index) -> control bits.
module seq_uop_rom
  import seq_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  op_e        op_i,
  input  logic [1:0] step_i,
  output uop_t       uop_o
);

  localparam logic [1:0] MulLast = 2'(MUL_LATENCY - 1);

  always_comb begin
    uop_o = '0;
    case (op_i)
      OpAdd32: begin
        uop_o.valid = 1'b1;
        if (step_i == 2'd0) begin
          uop_o.exe_cmd    = ExeAdd;
          uop_o.carry_hold = 1'b1;
        end else begin
          uop_o.exe_cmd = ExeAdc;
          uop_o.wb_en   = 1'b1;
          uop_o.hi_sel  = 1'b1;
          uop_o.last    = 1'b1;
        end
      end
      OpMul: begin
        if (step_i == 2'd0) begin
          uop_o.valid   = 1'b1;
          uop_o.exe_cmd = ExeMulLo;
          uop_o.wb_en   = 1'b1;
        end else if (step_i == MulLast) begin
          uop_o.valid   = 1'b1;
          uop_o.exe_cmd = ExeMulHi;
          uop_o.wb_en   = 1'b1;
          uop_o.hi_sel  = 1'b1;
          uop_o.last    = 1'b1;
        end
        // Middle steps only wait on the multiplier pipeline.
      end
      OpPush: begin
        uop_o.valid = 1'b1;
        if (step_i == 2'd0) begin
          uop_o.exe_cmd = ExeSub;
          uop_o.wb_en   = 1'b1;
          uop_o.sp_sel  = 1'b1;
        end else begin
          uop_o.exe_cmd   = ExeAdd;
          uop_o.mem_write = 1'b1;
          uop_o.last      = 1'b1;
        end
      end
      OpPop: begin
        uop_o.valid   = 1'b1;
        uop_o.exe_cmd = ExeAdd;
        uop_o.wb_en   = 1'b1;
        if (step_i == 2'd0) begin
          uop_o.mem_read = 1'b1;
        end else begin
          uop_o.sp_sel = 1'b1;
          uop_o.last   = 1'b1;
        end
      end
      default: uop_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer (ADD32/MUL/PUSH/POP) beside the ID control unit.
// Optional saturating performance counters are enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned SP_STEP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       status,
  input  logic       hazard,
  input  logic       stall,
  input  logic       flush,
  output logic       seq_active,
  output logic       uop_valid,
  output logic [1:0] step,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       sp_sel,
  output logic       hi_sel,
  output logic       carry_hold,
  output logic [3:0] sp_offset,
  output logic       freeze
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0] seq_count,
  output logic [15:0] freeze_cycles
`endif
);

  state_e     state_q, state_d;
  op_e        op_q, op_d, op_dec, rom_op;
  logic [1:0] cnt_q, cnt_d, rom_step;
  uop_t       uop;
  logic       issue, run_ok, run_go;

  assign op_dec    = decode_op(mode, opcode, status);
  assign sp_offset = 4'(SP_STEP);

  // rst gates the zero-latency issue path so outputs drop during reset.
  assign issue  = rst && (state_q == StIdle) && (op_dec != OpNone) && !hazard && !stall && !flush;
  assign run_ok = (state_q == StRun) && (op_q != OpNone);
  assign run_go = run_ok && !flush && !stall;

  assign rom_op   = (state_q == StRun) ? op_q : op_dec;
  assign rom_step = (state_q == StRun) ? cnt_q : 2'd0;

  seq_uop_rom #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_rom (
    .op_i  (rom_op),
    .step_i(rom_step),
    .uop_o (uop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StRun;
          op_d    = op_dec;
          cnt_d   = 2'd1;
        end
      end
      StRun: begin
        if (!run_ok || flush || (run_go && uop.last)) begin
          state_d = StIdle;
          op_d    = OpNone;
          cnt_d   = 2'd0;
        end else if (run_go) begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        op_d    = OpNone;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    seq_active = 1'b0;
    uop_valid  = 1'b0;
    step       = 2'd0;
    exe_cmd    = 4'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    wb_en      = 1'b0;
    sp_sel     = 1'b0;
    hi_sel     = 1'b0;
    carry_hold = 1'b0;
    freeze     = 1'b0;
    if (issue || run_ok) begin
      seq_active = 1'b1;
      step       = rom_step;
      if (issue || run_go) begin
        uop_valid  = uop.valid;
        exe_cmd    = uop.exe_cmd;
        mem_read   = uop.mem_read;
        mem_write  = uop.mem_write;
        wb_en      = uop.wb_en;
        sp_sel     = uop.sp_sel;
        hi_sel     = uop.hi_sel;
        carry_hold = uop.carry_hold;
        freeze     = !uop.last;
      end else if (!flush) begin
        freeze = 1'b1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] seq_count_q, seq_count_d, freeze_cycles_q, freeze_cycles_d;

  always_comb begin
    seq_count_d     = seq_count_q;
    freeze_cycles_d = freeze_cycles_q;
    if (run_go && uop.last && (seq_count_q != 16'hFFFF)) seq_count_d = seq_count_q + 16'd1;
    if (freeze && (freeze_cycles_q != 16'hFFFF)) freeze_cycles_d = freeze_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_count_q     <= 16'd0;
      freeze_cycles_q <= 16'd0;
    end else begin
      seq_count_q     <= seq_count_d;
      freeze_cycles_q <= freeze_cycles_d;
    end
  end

  assign seq_count     = seq_count_q;
  assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Table-driven bench for multicycle_sequencer plus a hand-written reset-mid-MUL sequence.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b01;
  logic [3:0] opcode = 4'd0;
  logic       status = 1'b0, hazard = 1'b0, stall = 1'b0, flush = 1'b0;
  logic       seq_active, uop_valid, mem_read, mem_write, wb_en, sp_sel, hi_sel;
  logic       carry_hold, freeze;
  logic [1:0] step;
  logic [3:0] exe_cmd, sp_offset;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] seq_count, freeze_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .opcode    (opcode),
    .status    (status),
    .hazard    (hazard),
    .stall     (stall),
    .flush     (flush),
    .seq_active(seq_active),
    .uop_valid (uop_valid),
    .step      (step),
    .exe_cmd   (exe_cmd),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .wb_en     (wb_en),
    .sp_sel    (sp_sel),
    .hi_sel    (hi_sel),
    .carry_hold(carry_hold),
    .sp_offset (sp_offset),
    .freeze    (freeze)
`ifdef SEQ_PERF_CNT_EN
    ,
    .seq_count    (seq_count),
    .freeze_cycles(freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  // {seq_active, uop_valid, step, exe_cmd, mem_read, mem_write, wb_en, sp_sel, hi_sel,
  //  carry_hold, freeze}
  logic [14:0] act;
  assign act = {seq_active, uop_valid, step, exe_cmd, mem_read, mem_write, wb_en, sp_sel,
                hi_sel, carry_hold, freeze};

  // Input patterns {mode, opcode, status}
  localparam logic [6:0] INone = {2'b01, 4'b0000, 1'b0};
  localparam logic [6:0] IAdd  = {2'b00, 4'b0011, 1'b0};
  localparam logic [6:0] IMul  = {2'b00, 4'b1110, 1'b0};
  localparam logic [6:0] IPush = {2'b11, 4'b0000, 1'b0};
  localparam logic [6:0] IPop  = {2'b11, 4'b0000, 1'b1};

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  ins;
    logic [2:0]  hsf;   // {hazard, stall, flush}
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] o(input logic sa, input logic uv, input logic [1:0] st,
                                    input logic [3:0] cmd, input logic mr, input logic mw,
                                    input logic wb, input logic sp, input logic hi,
                                    input logic ch, input logic fr);
    return {sa, uv, st, cmd, mr, mw, wb, sp, hi, ch, fr};
  endfunction

  task automatic add(input string n, input logic r, input logic [6:0] ins,
                     input logic [2:0] hsf, input logic [14:0] exp);
    vec_t v;
    v.name = n; v.rst = r; v.ins = ins; v.hsf = hsf; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [15:0] a, input logic [15:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] ins, input logic [2:0] hsf);
    rst = r;
    {mode, opcode, status} = ins;
    {hazard, stall, flush} = hsf;
  endtask

  logic [14:0] z;

  initial begin
    z = '0;
    add("reset",        1'b0, IAdd,  3'b000, z);
    add("idle_none",    1'b1, INone, 3'b000, z);
    add("add_s0",       1'b1, IAdd,  3'b000, o(1, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 1));
    add("add_s1",       1'b1, IAdd,  3'b000, o(1, 1, 1, 4'b0011, 0, 0, 1, 0, 1, 0, 0));
    add("add_idle",     1'b1, INone, 3'b000, z);
    add("mul_s0",       1'b1, IMul,  3'b000, o(1, 1, 0, 4'b1100, 0, 0, 1, 0, 0, 0, 1));
    add("mul_s1_wait",  1'b1, IMul,  3'b000, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    add("mul_s2",       1'b1, IMul,  3'b000, o(1, 1, 2, 4'b1101, 0, 0, 1, 0, 1, 0, 0));
    add("push_s0_b2b",  1'b1, IPush, 3'b000, o(1, 1, 0, 4'b0100, 0, 0, 1, 1, 0, 0, 1));
    add("push_stall1",  1'b1, IPush, 3'b010, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    add("push_stall2",  1'b1, IPush, 3'b010, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    add("push_s1",      1'b1, IPush, 3'b000, o(1, 1, 1, 4'b0010, 0, 1, 0, 0, 0, 0, 0));
    add("pop_hazard1",  1'b1, IPop,  3'b100, z);
    add("pop_hazard2",  1'b1, IPop,  3'b100, z);
    add("pop_s0",       1'b1, IPop,  3'b000, o(1, 1, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 1));
    add("pop_s1_hzign", 1'b1, IPop,  3'b100, o(1, 1, 1, 4'b0010, 0, 0, 1, 1, 0, 0, 0));
    add("add2_s0_b2b",  1'b1, IAdd,  3'b000, o(1, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 1));
    add("add2_flush",   1'b1, IAdd,  3'b001, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    add("flush_idle",   1'b1, INone, 3'b000, z);
    add("add3_s0",      1'b1, IAdd,  3'b000, o(1, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 1));
    add("stall_flush",  1'b1, IAdd,  3'b011, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    add("sf_idle",      1'b1, INone, 3'b000, z);
    add("idle_stall",   1'b1, IAdd,  3'b010, z);
    add("idle_flush",   1'b1, IAdd,  3'b001, z);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ins, vecs[i].hsf);
      #1;
      check(vecs[i].name, {1'b0, act}, {1'b0, vecs[i].exp});
      if (i == 0 || i == 9) check("sp_offset", {12'd0, sp_offset}, 16'd4);
`ifdef SEQ_PERF_CNT_EN
      if (i == 8) begin
        check("seq_count", seq_count, 16'd2);
        check("freeze_cycles", freeze_cycles, 16'd3);
      end
`endif
    end

    // Reset asserted in the middle of a MUL, then a clean PUSH.
    @(negedge clk);
    drive(1'b1, IMul, 3'b000);
    #1 check("rm_mul_s0", {1'b0, act}, {1'b0, o(1, 1, 0, 4'b1100, 0, 0, 1, 0, 0, 0, 1)});
    @(negedge clk);
    #1 check("rm_mul_s1", {1'b0, act}, {1'b0, o(1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1)});
    drive(1'b0, IMul, 3'b000);
    #1 check("rm_async_zero", {1'b0, act}, 16'd0);
    @(negedge clk);
    #1 check("rm_held_zero", {1'b0, act}, 16'd0);
    @(negedge clk);
    drive(1'b1, IPush, 3'b000);
    #1 check("rm_push_s0", {1'b0, act}, {1'b0, o(1, 1, 0, 4'b0100, 0, 0, 1, 1, 0, 0, 1)});
    @(negedge clk);
    #1 check("rm_push_s1", {1'b0, act}, {1'b0, o(1, 1, 1, 4'b0010, 0, 1, 0, 0, 0, 0, 0)});
    @(negedge clk);
    drive(1'b1, INone, 3'b000);
    #1 check("rm_idle", {1'b0, act}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
